// File: rtl/recompute_pkg.sv
// Shared types and width helpers for the recompute-unit repair allocator.
// No ports. Contents:
//   rmc_state_t     - allocator FSM states
//   row_idx_width   - width of a row index for a given row count (min 1 bit)
//   ru_count_width  - width of a counter that must hold 0..num_ru inclusive
package recompute_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } rmc_state_t;

  // $clog2(1) is 0, which is not a legal vector width, so clamp to 1 bit.
  function automatic int row_idx_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  // The RU count saturates at num_ru itself, so it needs num_ru+1 codes.
  function automatic int ru_count_width(input int num_ru);
    return $clog2(num_ru + 1);
  endfunction

endpackage

// File: rtl/row_fault_allocator.sv
// Combinational single-row allocator.
// Takes one row's fault vector (1 = faulty PE) and hands faulty columns, in
// ascending column order, to consecutive recompute units starting at count_in.
// Ports:
//   fault_vec   in  [COLS-1:0]           faulty-PE flags for this row
//   count_in    in  [CW-1:0]             RUs already used by earlier rows
//   row_idx     in  [RW-1:0]             index of the row being allocated
//   assign_en   out [NUM_RU-1:0]         RU k receives a PE from this row
//   row_onehot  out [ROWS-1:0]           one-hot of row_idx
//   col_onehot  out [COLS-1:0] x NUM_RU  one-hot column for each assigned RU
//   count_out   out [CW-1:0]             updated count, saturated at NUM_RU
module row_fault_allocator
  import recompute_pkg::*;
#(
  parameter int ROWS   = 3,
  parameter int COLS   = 3,
  parameter int NUM_RU = 3,
  parameter int RW     = row_idx_width(ROWS),
  parameter int CW     = ru_count_width(NUM_RU)
) (
  input  logic [COLS-1:0] fault_vec,
  input  logic [CW-1:0]   count_in,
  input  logic [RW-1:0]   row_idx,
  output logic [NUM_RU-1:0] assign_en,
  output logic [ROWS-1:0] row_onehot,
  output logic [COLS-1:0] col_onehot [NUM_RU-1:0],
  output logic [CW-1:0]   count_out
);

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row_oh
      assign row_onehot[gi] = (row_idx == RW'(gi));
    end
  endgenerate

  // slot walks the RU index the next faulty column would occupy; it is the
  // running prefix count of faults plus the RUs consumed by earlier rows.
  always_comb begin
    int slot;
    assign_en = '0;
    for (int k = 0; k < NUM_RU; k++) begin
      col_onehot[k] = '0;
    end
    slot = int'(count_in);
    for (int c = 0; c < COLS; c++) begin
      if (fault_vec[c]) begin
        for (int k = 0; k < NUM_RU; k++) begin
          if (k == slot) begin
            assign_en[k]     = 1'b1;
            col_onehot[k][c] = 1'b1;
          end
        end
        slot = slot + 1;
      end
    end
    count_out = (slot > NUM_RU) ? CW'(NUM_RU) : CW'(slot);
  end

endmodule

// File: rtl/recompute_module_controller.sv
// Built-in self-repair allocator for a ROWS x COLS systolic array with NUM_RU
// spare recompute units. Snapshots the self-test pass/fail map one cycle after
// reset release, then walks it one row per cycle, binding faulty PEs in
// row-major order to RUs and holding the resulting operand selects.
// Optional status outputs are built when macro RMC_STATUS_EN is defined.
// Ports:
//   clk             in   rising-edge clock
//   rst             in   asynchronous active-high reset
//   STW_result_mat  in   per-PE result, 1 = pass, 0 = faulty
//   dataRow/Col     out  one-hot data operand row/column select per RU
//   weightRow/Col   out  one-hot weight operand row/column select per RU
//   alloc_done      out  (RMC_STATUS_EN) allocation finished
//   ru_valid        out  (RMC_STATUS_EN) RU k holds an assignment
//   ru_overflow     out  (RMC_STATUS_EN) sticky: at least one fault dropped
module recompute_module_controller
  import recompute_pkg::*;
#(
  parameter int ROWS   = 3,
  parameter int COLS   = 3,
  parameter int NUM_RU = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            STW_result_mat [0:ROWS-1][0:COLS-1],
  output logic [ROWS-1:0] dataRow   [NUM_RU-1:0],
  output logic [COLS-1:0] dataCol   [NUM_RU-1:0],
  output logic [ROWS-1:0] weightRow [NUM_RU-1:0],
  output logic [COLS-1:0] weightCol [NUM_RU-1:0]
`ifdef RMC_STATUS_EN
  ,
  output logic              alloc_done,
  output logic [NUM_RU-1:0] ru_valid,
  output logic              ru_overflow
`endif
);

  localparam int RW = row_idx_width(ROWS);
  localparam int CW = ru_count_width(NUM_RU);

  rmc_state_t      state_q, state_d;
  logic [RW-1:0]   row_idx_q, row_idx_d;
  logic [CW-1:0]   count_q, count_d;
  logic [COLS-1:0] pass_q [ROWS], pass_d [ROWS];
  logic [ROWS-1:0] sel_row_q [NUM_RU-1:0], sel_row_d [NUM_RU-1:0];
  logic [COLS-1:0] sel_col_q [NUM_RU-1:0], sel_col_d [NUM_RU-1:0];

  logic [COLS-1:0]   cur_fault;
  logic [NUM_RU-1:0] alloc_en;
  logic [ROWS-1:0]   alloc_row_oh;
  logic [COLS-1:0]   alloc_col_oh [NUM_RU-1:0];
  logic [CW-1:0]     alloc_count;
  logic              alloc_active;

`ifdef RMC_STATUS_EN
  logic [NUM_RU-1:0] ru_valid_q, ru_valid_d;
  logic              ru_overflow_q, ru_overflow_d;
`endif

  // The snapshot stores pass bits; the allocator wants fault bits.
  assign cur_fault    = ~pass_q[row_idx_q];
  // Row 0 is allocated during LATCH so that row r lands on edge r+2.
  assign alloc_active = (state_q == LATCH) || (state_q == SCAN);

  row_fault_allocator #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .NUM_RU (NUM_RU),
    .RW     (RW),
    .CW     (CW)
  ) u_row_alloc (
    .fault_vec  (cur_fault),
    .count_in   (count_q),
    .row_idx    (row_idx_q),
    .assign_en  (alloc_en),
    .row_onehot (alloc_row_oh),
    .col_onehot (alloc_col_oh),
    .count_out  (alloc_count)
  );

  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    count_d   = count_q;
    for (int r = 0; r < ROWS; r++) begin
      pass_d[r] = pass_q[r];
    end
    for (int k = 0; k < NUM_RU; k++) begin
      sel_row_d[k] = sel_row_q[k];
      sel_col_d[k] = sel_col_q[k];
    end
`ifdef RMC_STATUS_EN
    ru_valid_d    = ru_valid_q;
    ru_overflow_d = ru_overflow_q;
`endif

    unique case (state_q)
      // First edge after reset release: capture the map, start from RU 0.
      IDLE: begin
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            pass_d[r][c] = STW_result_mat[r][c];
          end
        end
        count_d   = '0;
        row_idx_d = '0;
        state_d   = LATCH;
      end
      LATCH, SCAN: begin
        count_d = alloc_count;
        if (row_idx_q == RW'(ROWS - 1)) begin
          state_d = DONE;
        end else begin
          row_idx_d = row_idx_q + RW'(1);
          state_d   = SCAN;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // An RU is written only in the cycle it is bound, so each select changes
    // at most once between resets.
    for (int k = 0; k < NUM_RU; k++) begin
      if (alloc_active && alloc_en[k]) begin
        sel_row_d[k] = alloc_row_oh;
        sel_col_d[k] = alloc_col_oh[k];
      end
    end

`ifdef RMC_STATUS_EN
    if (alloc_active) begin
      ru_valid_d = ru_valid_q | alloc_en;
      // Every fault in the row that did not get an RU was dropped.
      if ($countones(cur_fault) != $countones(alloc_en)) begin
        ru_overflow_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      row_idx_q <= '0;
      count_q   <= '0;
      for (int r = 0; r < ROWS; r++) begin
        pass_q[r] <= '1;
      end
      for (int k = 0; k < NUM_RU; k++) begin
        sel_row_q[k] <= '0;
        sel_col_q[k] <= '0;
      end
`ifdef RMC_STATUS_EN
      ru_valid_q    <= '0;
      ru_overflow_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      count_q   <= count_d;
      for (int r = 0; r < ROWS; r++) begin
        pass_q[r] <= pass_d[r];
      end
      for (int k = 0; k < NUM_RU; k++) begin
        sel_row_q[k] <= sel_row_d[k];
        sel_col_q[k] <= sel_col_d[k];
      end
`ifdef RMC_STATUS_EN
      ru_valid_q    <= ru_valid_d;
      ru_overflow_q <= ru_overflow_d;
`endif
    end
  end

  // Data and weight operands of a PE share its coordinates.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_RU; gi++) begin : g_ru_out
      assign dataRow[gi]   = sel_row_q[gi];
      assign dataCol[gi]   = sel_col_q[gi];
      assign weightRow[gi] = sel_row_q[gi];
      assign weightCol[gi] = sel_col_q[gi];
    end
  endgenerate

`ifdef RMC_STATUS_EN
  assign alloc_done  = (state_q == DONE);
  assign ru_valid    = ru_valid_q;
  assign ru_overflow = ru_overflow_q;
`endif

endmodule

// File: tb/tb_recompute_module_controller.sv
module tb_recompute_module_controller;

  localparam int ROWS   = 3;
  localparam int COLS   = 3;
  localparam int NUM_RU = 3;

  logic       clk;
  logic       rst;
  logic       STW_result_mat [0:ROWS-1][0:COLS-1];
  logic [2:0] dataRow   [NUM_RU-1:0];
  logic [2:0] dataCol   [NUM_RU-1:0];
  logic [2:0] weightRow [NUM_RU-1:0];
  logic [2:0] weightCol [NUM_RU-1:0];
`ifdef RMC_STATUS_EN
  logic       alloc_done;
  logic [2:0] ru_valid;
  logic       ru_overflow;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // Expected values, filled by the reference model or the vector table.
  logic [2:0] exp_row [NUM_RU];
  logic [2:0] exp_col [NUM_RU];
  logic [2:0] exp_valid;
  logic       exp_ovf;
  logic       exp_done;

  recompute_module_controller #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .NUM_RU (NUM_RU)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .STW_result_mat (STW_result_mat),
    .dataRow        (dataRow),
    .dataCol        (dataCol),
    .weightRow      (weightRow),
    .weightCol      (weightCol)
`ifdef RMC_STATUS_EN
    ,
    .alloc_done     (alloc_done),
    .ru_valid       (ru_valid),
    .ru_overflow    (ru_overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input int idx, input logic [2:0] got, input logic [2:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s[%0d]: got %b, expected %b", name, idx, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NUM_RU; k++) begin
      cmp({tag, ".dataRow"},   k, dataRow[k],   exp_row[k]);
      cmp({tag, ".dataCol"},   k, dataCol[k],   exp_col[k]);
      cmp({tag, ".weightRow"}, k, weightRow[k], exp_row[k]);
      cmp({tag, ".weightCol"}, k, weightCol[k], exp_col[k]);
    end
`ifdef RMC_STATUS_EN
    cmp({tag, ".alloc_done"},  0, {2'b00, alloc_done},  {2'b00, exp_done});
    cmp({tag, ".ru_valid"},    0, ru_valid,             exp_valid);
    cmp({tag, ".ru_overflow"}, 0, {2'b00, ru_overflow}, {2'b00, exp_ovf});
`endif
  endtask

  // pass bit index is r*COLS+c; 1 = pass.
  task automatic set_map(input logic [8:0] pass);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        STW_result_mat[r][c] = pass[r*COLS+c];
  endtask

  // Reference model: list every faulty PE in row-major order; the i-th one
  // owns RU i if i < NUM_RU. Only rows already scanned are visible.
  task automatic model(input logic [8:0] pass, input int rows_done, input bit done);
    int fr[$];
    int fc[$];
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!pass[r*COLS+c]) begin
          fr.push_back(r);
          fc.push_back(c);
        end
    exp_valid = '0;
    exp_ovf   = 1'b0;
    exp_done  = done;
    for (int k = 0; k < NUM_RU; k++) begin
      exp_row[k] = '0;
      exp_col[k] = '0;
      if (k < fr.size() && fr[k] < rows_done) begin
        exp_row[k]   = 3'(1 << fr[k]);
        exp_col[k]   = 3'(1 << fc[k]);
        exp_valid[k] = 1'b1;
      end
    end
    for (int i = NUM_RU; i < fr.size(); i++)
      if (fr[i] < rows_done) exp_ovf = 1'b1;
  endtask

  // Reset, release with a map, and check every edge up to one past DONE.
  // With scramble set, the input map is randomised after the snapshot edge.
  task automatic run_map(input logic [8:0] pass, input bit scramble, input string tag);
    int rows_done;
    rst = 1'b1;
    set_map(pass);
    @(negedge clk);
    model(pass, 0, 1'b0);
    check_all({tag, ".reset"});
    rst = 1'b0;
    for (int e = 1; e <= ROWS + 2; e++) begin
      @(negedge clk);
      rows_done = (e - 1 > ROWS) ? ROWS : e - 1;
      model(pass, rows_done, e >= ROWS + 1);
      check_all($sformatf("%s.edge%0d", tag, e));
      if (scramble) set_map(9'($urandom));
    end
    $display("[TB] run %s map=%b scramble=%0d done", tag, pass, scramble);
  endtask

  typedef struct {
    logic [8:0] pass;
    logic [8:0] er;  // RU k row one-hot in er[3k +: 3]
    logic [8:0] ec;
    logic       ovf;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [8:0] p;
    rst = 1'b1;
    set_map('1);

    // {pass map, expected final rows, expected final cols, overflow}
    vecs[0] = '{9'b101101110, {3'b100, 3'b010, 3'b001}, {3'b010, 3'b010, 3'b001}, 1'b0};
    vecs[1] = '{9'b111111111, 9'b0, 9'b0, 1'b0};
    vecs[2] = '{9'b011110000, {3'b001, 3'b001, 3'b001}, {3'b100, 3'b010, 3'b001}, 1'b1};
    vecs[3] = '{9'b011111111, {3'b000, 3'b000, 3'b100}, {3'b000, 3'b000, 3'b100}, 1'b0};
    vecs[4] = '{9'b111011111, {3'b000, 3'b000, 3'b010}, {3'b000, 3'b000, 3'b100}, 1'b0};

    for (int i = 0; i < 5; i++) begin
      run_map(vecs[i].pass, 1'b0, $sformatf("vec%0d", i));
      p = vecs[i].er;
      for (int k = 0; k < NUM_RU; k++) begin
        exp_row[k]   = p[3*k +: 3];
        exp_valid[k] = |p[3*k +: 3];
      end
      p = vecs[i].ec;
      for (int k = 0; k < NUM_RU; k++) exp_col[k] = p[3*k +: 3];
      exp_ovf  = vecs[i].ovf;
      exp_done = 1'b1;
      check_all($sformatf("vec%0d.final", i));
    end

    // Reset in the middle of a scan clears outputs without a clock edge,
    // then a new map is allocated from scratch.
    rst = 1'b1;
    set_map(9'b101101110);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model(9'b101101110, 1, 1'b0);
    check_all("midscan.edge2");
    #1 rst = 1'b1;
    #1;
    model(9'b101101110, 0, 1'b0);
    check_all("midscan.async_clear");
    run_map(9'b111011111, 1'b0, "midscan.restart");

    // Input changing every cycle after the snapshot must not matter.
    run_map(9'b101101110, 1'b1, "scramble_t1");
    run_map(9'b011110000, 1'b1, "scramble_t3");

    // Random maps against the model.
    for (int i = 0; i < 40; i++) begin
      p = 9'($urandom);
      if (i % 2 == 0) p = p | 9'($urandom);
      run_map(p, (i % 3) == 0, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
